zap_fetch_fifo: RTL and testbench

Instruction prefetch buffer between the fetch stage and the decode stage. It captures every valid fetch output along with its PC, PC+8, abort flag, branch-state and prediction sidebands. It presents these to decode in order, and absorbs decode-side stalls without losing the instruction already in flight from fetch. It applies back-pressure to fetch through a registered-count stall, and discards all contents on any pipeline flush.

---
 rtl/zap_fetch_fifo.sv | 117 +++++++++++
 tb/tb_zap_fetch_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/zap_fetch_fifo.sv
// rtl/zap_fetch_fifo.sv - instruction prefetch buffer between fetch and decode
module zap_fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_stall,
  input  logic        i_valid,
  input  logic [31:0] i_instruction,
  input  logic        i_instr_abort,
  input  logic [31:0] i_pc_plus_8,
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_taken,
  input  logic [32:0] i_pred,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic        o_instr_abort,
  output logic [31:0] o_pc_plus_8,
  output logic [31:0] o_pc,
  output logic [1:0]  o_taken,
  output logic [32:0] o_pred,
  output logic        o_stall,
  output logic        o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 32 + 1 + 32 + 32 + 2 + 33;

  // Entry layout: {instruction, abort, pc_plus_8, pc, taken, pred}
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;

  // Handshake decode: a full buffer still accepts when the head leaves this cycle
  always_comb begin
    pop      = (count_q != '0) && !i_stall;
    push     = i_valid && ((count_q < CW'(DEPTH)) || pop);
    drop     = i_valid && !push;
    wr_entry = {i_instruction, i_instr_abort, i_pc_plus_8, i_pc, i_taken, i_pred};
  end

  // Next-state for pointers, occupancy and the sticky overflow flag; flush wins over push/pop
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are not reset, validity is tracked by count_q alone
  always_ff @(posedge i_clk) begin
    if (push && !i_clear && !i_reset) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Head presentation: zeros when empty so decode never sees stale entries
  always_comb begin
    head_entry = mem_q[rd_ptr_q];
    o_valid    = (count_q != '0);
    if (o_valid) begin
      {o_instruction, o_instr_abort, o_pc_plus_8, o_pc, o_taken, o_pred} = head_entry;
    end else begin
      {o_instruction, o_instr_abort, o_pc_plus_8, o_pc, o_taken, o_pred} = '0;
    end
    // Stall one slot early so the word already in flight from fetch still fits
    o_stall    = (count_q >= CW'(DEPTH - 1));
    o_overflow = overflow_q;
  end

endmodule

// File: tb/tb_zap_fetch_fifo.sv
// tb/tb_zap_fetch_fifo.sv - randomized self-checking bench for zap_fetch_fifo
module tb_zap_fetch_fifo;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_reset, i_clear, i_stall, i_valid;
  logic [31:0] i_instruction, i_pc_plus_8, i_pc;
  logic        i_instr_abort;
  logic [1:0]  i_taken;
  logic [32:0] i_pred;
  logic        o_valid, o_instr_abort, o_stall, o_overflow;
  logic [31:0] o_instruction, o_pc_plus_8, o_pc;
  logic [1:0]  o_taken;
  logic [32:0] o_pred;

  int errs   = 0;
  int checks = 0;

  logic [131:0] mq[$];
  bit           movf;

  zap_fetch_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_stall(i_stall),
    .i_valid(i_valid), .i_instruction(i_instruction), .i_instr_abort(i_instr_abort),
    .i_pc_plus_8(i_pc_plus_8), .i_pc(i_pc), .i_taken(i_taken), .i_pred(i_pred),
    .o_valid(o_valid), .o_instruction(o_instruction), .o_instr_abort(o_instr_abort),
    .o_pc_plus_8(o_pc_plus_8), .o_pc(o_pc), .o_taken(o_taken), .o_pred(o_pred),
    .o_stall(o_stall), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [131:0] got, input logic [131:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                        input bit ab, input logic [1:0] tk, input logic [32:0] pr);
    i_valid       = v;
    i_instruction = instr;
    i_pc          = pc;
    i_pc_plus_8   = pc + 32'd8;
    i_instr_abort = ab;
    i_taken       = tk;
    i_pred        = pr;
  endtask

  // Reference model: a bounded queue updated with the inputs present at the coming edge
  task automatic model_step();
    bit pop_m, push_m;
    if (i_reset) begin
      mq.delete();
      movf = 1'b0;
    end else if (i_clear) begin
      mq.delete();
    end else begin
      pop_m  = (mq.size() != 0) && !i_stall;
      push_m = i_valid && ((mq.size() < DEPTH) || pop_m);
      if (i_valid && !push_m) movf = 1'b1;
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back({i_instruction, i_instr_abort, i_pc_plus_8, i_pc, i_taken, i_pred});
    end
  endtask

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (mq.size() != 0);
    check_eq("o_valid", 132'(o_valid), 132'(exp_valid));
    check_eq("o_stall", 132'(o_stall), 132'(mq.size() >= DEPTH - 1));
    check_eq("o_overflow", 132'(o_overflow), 132'(movf));
    check_eq("head", {o_instruction, o_instr_abort, o_pc_plus_8, o_pc, o_taken, o_pred},
             exp_valid ? mq[0] : 132'd0);
  endtask

  task automatic cyc();
    model_step();
    @(posedge i_clk);
    #1;
    check_outputs();
  endtask

  initial begin
    mq.delete();
    movf    = 1'b0;
    i_reset = 1'b1;
    i_clear = 1'b0;
    i_stall = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 33'd0);
    cyc();
    cyc();
    check_eq("reset_valid", 132'(o_valid), 132'd0);
    check_eq("reset_stall", 132'(o_stall), 132'd0);
    i_reset = 1'b0;
    cyc();

    // Streaming: 8 back-to-back pushes, head trails input by one cycle
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 32'hE000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 2'd0, 33'd0);
      cyc();
      check_eq("stream_pc", 132'(o_pc), 132'(32'h100 + 32'(4 * i)));
      check_eq("stream_nostall", 132'(o_stall), 132'd0);
    end
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 33'd0);
    cyc();

    // Fill under stall
    i_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'hE1A0_0000 + 32'(i), 32'h180 + 32'(4 * i), 1'b0, 2'd0, 33'd0);
      cyc();
      if (i == 2) check_eq("fill_stall3", 132'(o_stall), 132'd1);
    end
    check_eq("fill_noovf", 132'(o_overflow), 132'd0);
    check_eq("fill_head", 132'(o_instruction), 132'(32'hE1A0_0000));

    // Full with simultaneous push and pop
    i_stall = 1'b0;
    set_in(1'b1, 32'hE1A0_0004, 32'h200, 1'b0, 2'd0, 33'd0);
    cyc();
    check_eq("full_pp_stall", 132'(o_stall), 132'd1);
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 33'd0);
    cyc();
    cyc();
    cyc();
    check_eq("full_pp_order", 132'(o_pc), 132'(32'h200));
    cyc();

    // Flush with a same-cycle push
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'hE3A0_0000 + 32'(i), 32'h280 + 32'(4 * i), 1'b0, 2'd0, 33'd0);
      cyc();
    end
    i_clear = 1'b1;
    set_in(1'b1, 32'hE3A0_0300, 32'h300, 1'b0, 2'd0, 33'd0);
    cyc();
    check_eq("flush_valid", 132'(o_valid), 132'd0);
    check_eq("flush_stall", 132'(o_stall), 132'd0);
    check_eq("flush_pc", 132'(o_pc), 132'd0);
    i_clear = 1'b0;
    i_stall = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 33'd0);
    cyc();
    check_eq("flush_no300", 132'(o_valid), 132'd0);

    // Abort and sideband passthrough
    set_in(1'b1, 32'hE59F_0000, 32'h400, 1'b1, 2'b11, 33'h1_0000_0400);
    cyc();
    check_eq("sb_abort", 132'(o_instr_abort), 132'd1);
    check_eq("sb_taken", 132'(o_taken), 132'(2'b11));
    check_eq("sb_pred", 132'(o_pred), 132'(33'h1_0000_0400));
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 33'd0);
    cyc();

    // Overflow is sticky until reset
    i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'hE1A0_1000 + 32'(i), 32'h500 + 32'(4 * i), 1'b0, 2'd0, 33'd0);
      cyc();
    end
    check_eq("ovf_set", 132'(o_overflow), 132'd1);
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 33'd0);
    i_stall = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    check_eq("ovf_sticky", 132'(o_overflow), 132'd1);
    i_stall = 1'b1;
    set_in(1'b1, 32'hE1A0_2000, 32'h600, 1'b0, 2'd0, 33'd0);
    cyc();
    i_reset = 1'b1;
    cyc();
    check_eq("rst_ovf", 132'(o_overflow), 132'd0);
    check_eq("rst_valid", 132'(o_valid), 132'd0);
    i_reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      i_reset = ($urandom_range(0, 399) == 0);
      i_clear = ($urandom_range(0, 29) == 0);
      i_stall = ($urandom_range(0, 2) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom),
             2'($urandom), {1'($urandom), $urandom});
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
